data_break_ctl: RTL and testbench

- Single-channel data-break (DMA) engine sitting directly downstream of the RK8E disk controller.
- Consumes the controller's break request (data_break, dmaAddr, to_disk, dmaDOUT), steals one memory cycle at a CPU instruction boundary, and performs the word transfer against main memory.
- Returns memory data for disk writes (feeds the controller's dmaDIN) and drives the DB0/DB1 state codes the controller uses to drop its request.

---
 rtl/data_break_ctl.sv | 197 +++++++++++++++++++
 tb/tb_data_break_ctl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_break_ctl.sv
// ---------------------------------------------------------------------------
// data_break_ctl
//
// Single-channel data-break engine placed behind the RK8E disk controller.
// A break request is latched in IDLE, held until the CPU reaches an
// instruction boundary, then one memory cycle is stolen to move one word
// between the controller and main memory.  The DB0/DB1 codes on db_state
// let the controller see the transfer and drop its request.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   clear         IOCLR/CAF, synchronous abort (same effect as reset)
//   data_break    break request level from the disk controller
//   to_disk       1 = memory read (memory -> disk), 0 = memory write
//   dma_addr      field + address of the word
//   dma_wdata     word from disk to be written to memory
//   cycle_end     CPU is at an instruction boundary
//   mem_rdata     memory read data
//   db_state      IDLE_CODE / DB0_CODE / DB1_CODE
//   break_in_prog break accepted and not yet finished
//   cpu_hold      CPU must not start a memory cycle
//   mem_addr      memory address (0 outside the memory phase)
//   mem_wdata     memory write data (0 outside the memory phase)
//   mem_we        one-clock write strobe
//   mem_re        read strobe, MEM_LAT clocks long
//   dma_rdata     captured read word returned to the disk controller
//   data_late     sticky, request waited >= LATE_LIMIT clocks
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no break; a data_break latches the request
// S_WAIT    | request held until cycle_end; late counter running
// S_DB0     | address phase; write strobe, or first read strobe clock
// S_RD_WAIT | remaining read strobe clocks; data captured on the last
// S_DB1     | completion code for exactly one clock
// S_RELEASE | one dead clock while the controller drops its request
// ---------------------------------------------------------------------------
module data_break_ctl #(
    parameter logic [4:0]  DB0_CODE   = 5'd16,
    parameter logic [4:0]  DB1_CODE   = 5'd17,
    parameter logic [4:0]  IDLE_CODE  = 5'd0,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned LATE_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        data_break,
    input  logic        to_disk,
    input  logic [0:14] dma_addr,
    input  logic [0:11] dma_wdata,
    input  logic        cycle_end,
    input  logic [0:11] mem_rdata,
    output logic [4:0]  db_state,
    output logic        break_in_prog,
    output logic        cpu_hold,
    output logic [0:14] mem_addr,
    output logic [0:11] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [0:11] dma_rdata,
    output logic        data_late
);

    localparam int unsigned        LATE_W  = 10;
    localparam logic [2:0]         RD_LAST = 3'(MEM_LAT - 1);
    localparam logic [LATE_W-1:0]  LATE_TC = LATE_W'(LATE_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DB0,
        S_RD_WAIT,
        S_DB1,
        S_RELEASE
    } state_t;

    state_t             state_q,    state_d;
    logic [0:14]        addr_q,     addr_d;
    logic [0:11]        wdata_q,    wdata_d;
    logic               rd_q,       rd_d;
    logic [2:0]         lat_cnt_q,  lat_cnt_d;
    logic [LATE_W-1:0]  late_cnt_q, late_cnt_d;
    logic               late_q,     late_d;
    logic [0:11]        rdata_q,    rdata_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        lat_cnt_d     = lat_cnt_q;
        late_cnt_d    = late_cnt_q;
        late_d        = late_q;
        rdata_d       = rdata_q;

        db_state      = IDLE_CODE;
        break_in_prog = 1'b0;
        cpu_hold      = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_break) begin
                    addr_d     = dma_addr;
                    wdata_d    = dma_wdata;
                    rd_d       = to_disk;
                    late_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end

            S_WAIT: begin
                break_in_prog = 1'b1;
                if (cycle_end) begin
                    // down-counter for the read strobe: 0 marks the capture clock
                    lat_cnt_d = RD_LAST;
                    state_d   = S_DB0;
                end else begin
                    if (late_cnt_q != '1) begin
                        late_cnt_d = late_cnt_q + 1'b1;
                    end
                    if (late_cnt_d >= LATE_TC) begin
                        late_d = 1'b1;
                    end
                end
            end

            S_DB0, S_RD_WAIT: begin
                db_state      = DB0_CODE;
                break_in_prog = 1'b1;
                cpu_hold      = 1'b1;
                mem_addr      = addr_q;
                if (!rd_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = S_DB1;
                end else begin
                    mem_re = 1'b1;
                    if (lat_cnt_q == 3'd0) begin
                        rdata_d = mem_rdata;
                        state_d = S_DB1;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 1'b1;
                        state_d   = S_RD_WAIT;
                    end
                end
            end

            S_DB1: begin
                db_state      = DB1_CODE;
                break_in_prog = 1'b1;
                cpu_hold      = 1'b1;
                state_d       = S_RELEASE;
            end

            S_RELEASE: begin
                // controller is still dropping its registered request here
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            lat_cnt_q  <= '0;
            late_cnt_q <= '0;
            late_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            lat_cnt_q  <= lat_cnt_d;
            late_cnt_q <= late_cnt_d;
            late_q     <= late_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dma_rdata = rdata_q;
    assign data_late = late_q;

endmodule

// File: tb/tb_data_break_ctl.sv
module tb_data_break_ctl;

    localparam int         MEM_LAT    = 3;
    localparam int         LATE_LIMIT = 255;
    localparam logic [4:0] DB0C       = 5'd16;
    localparam logic [4:0] DB1C       = 5'd17;
    localparam logic [4:0] IDLEC      = 5'd0;
    localparam int         INF        = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset, clear, data_break, to_disk, cycle_end;
    logic [0:14] dma_addr;
    logic [0:11] dma_wdata;
    logic [0:11] mem_rdata;
    logic [4:0]  db_state;
    logic        break_in_prog, cpu_hold, mem_we, mem_re, data_late;
    logic [0:14] mem_addr;
    logic [0:11] mem_wdata, dma_rdata;

    data_break_ctl #(
        .DB0_CODE  (DB0C),
        .DB1_CODE  (DB1C),
        .IDLE_CODE (IDLEC),
        .MEM_LAT   (MEM_LAT),
        .LATE_LIMIT(LATE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .data_break   (data_break),
        .to_disk      (to_disk),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .cycle_end    (cycle_end),
        .mem_rdata    (mem_rdata),
        .db_state     (db_state),
        .break_in_prog(break_in_prog),
        .cpu_hold     (cpu_hold),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .dma_rdata    (dma_rdata),
        .data_late    (data_late)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] init_word(input int a);
        logic [11:0] v;
        if (a == 'o200) return 12'o1234;
        v = 12'((a * 13) + (a >> 4)) ^ 12'o5252;
        return v;
    endfunction

    // memory model: data is valid only on the MEM_LAT-th consecutive mem_re clock
    logic [11:0] dmem [0:32767];
    bit          filled = 0;
    int          re_run = 0;
    logic [0:11] junk_q = '0;

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 32768; i++) dmem[i] = init_word(i);
            filled = 1;
        end
        if (mem_we) dmem[mem_addr] = mem_wdata;
        re_run <= mem_re ? re_run + 1 : 0;
        junk_q <= 12'($urandom);
    end

    assign mem_rdata = (mem_re && re_run == MEM_LAT - 1) ? dmem[mem_addr] : junk_q;

    // reference model and scoreboard
    typedef struct {
        bit          rd;
        logic [0:14] a;
        logic [11:0] d;
        int          db1;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] ref_mem [0:32767];
    logic [0:14] pool [8];
    int          tests = 0;
    int          fails = 0;
    int          late_on = INF;
    bit          run = 0;
    bit          rst_q = 1;
    int          we_cnt = 0;
    int          re_cnt = 0;
    bit          prev_db1 = 0;

    always @(posedge clk) rst_q <= reset | clear;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            exp_t e;
            chk("data_late", {31'd0, data_late}, {31'd0, cyc >= late_on});
            if (rst_q) begin
                chk("reset_db_state", {27'd0, db_state}, {27'd0, IDLEC});
                chk("reset_ctrl", {28'd0, break_in_prog, cpu_hold, mem_we, mem_re}, 32'd0);
                chk("reset_dma_rdata", {20'd0, dma_rdata}, 32'd0);
                we_cnt = 0;
                re_cnt = 0;
            end else begin
                chk("db_state_legal",
                    {31'd0, (db_state == IDLEC) || (db_state == DB0C) || (db_state == DB1C)}, 32'd1);
                if (db_state != DB0C) begin
                    chk("bus_idle", {3'd0, mem_addr, mem_wdata, mem_we, mem_re}, 32'd0);
                end else begin
                    chk("hold_db0", {30'd0, cpu_hold, break_in_prog}, 32'd3);
                    if (exp_q.size() > 0) chk("mem_addr", {17'd0, mem_addr}, {17'd0, exp_q[0].a});
                    if (mem_we) begin
                        we_cnt++;
                        if (exp_q.size() > 0) chk("mem_wdata", {20'd0, mem_wdata}, {20'd0, exp_q[0].d});
                    end
                    if (mem_re) re_cnt++;
                end
                if (db_state == DB1C) begin
                    chk("hold_db1", {30'd0, cpu_hold, break_in_prog}, 32'd3);
                    chk("db1_single_clock", {31'd0, prev_db1}, 32'd0);
                    chk("db1_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("db1_cycle", cyc, e.db1);
                        if (e.rd) begin
                            chk("rd_strobe_clocks", re_cnt, MEM_LAT);
                            chk("rd_no_write", we_cnt, 0);
                            chk("dma_rdata", {20'd0, dma_rdata}, {20'd0, e.d});
                        end else begin
                            chk("we_pulses", we_cnt, 1);
                            chk("wr_no_read", re_cnt, 0);
                        end
                    end
                    we_cnt = 0;
                    re_cnt = 0;
                end
            end
            prev_db1 = (db_state == DB1C);
        end
    end

    // stimulus: inputs change 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            step();
            reset      = 0;
            clear      = 0;
            data_break = 0;
            cycle_end  = 1'($urandom);
            to_disk    = 1'($urandom);
            dma_addr   = 15'($urandom);
            dma_wdata  = 12'($urandom);
        end
    endtask

    // abort: 0 none, 1 clear in WAIT (needs w >= 1), 2 clear in first RD_WAIT clock (read only)
    task automatic do_xfer(input bit rd, input logic [0:14] a, input logic [11:0] wd,
                           input int w, input int abort);
        exp_t e;
        int   n, last;
        step();
        reset      = 0;
        clear      = 0;
        data_break = 1;
        to_disk    = rd;
        dma_addr   = a;
        dma_wdata  = wd;
        cycle_end  = 1'($urandom);
        n          = cyc;
        e.rd       = rd;
        e.a        = a;
        e.d        = rd ? ref_mem[a] : wd;
        e.db1      = n + 2 + w + (rd ? MEM_LAT : 1);
        exp_q.push_back(e);
        if (!rd && abort == 0) ref_mem[a] = wd;
        if (w >= LATE_LIMIT && late_on == INF) late_on = n + LATE_LIMIT + 1;
        if (abort == 1)      last = n + 1 + $urandom_range(0, w - 1);
        else if (abort == 2) last = n + 3 + w;
        else                 last = e.db1 + 1;
        for (int c = n + 1; c <= last; c++) begin
            step();
            data_break = 1'($urandom);
            to_disk    = 1'($urandom);
            dma_addr   = 15'($urandom);
            dma_wdata  = 12'($urandom);
            cycle_end  = (c <= n + w) ? 1'b0 : (c == n + w + 1) ? 1'b1 : 1'($urandom);
            if (abort != 0 && c == last) clear = 1;
        end
        if (abort != 0) begin
            step();
            clear      = 0;
            data_break = 0;
            late_on    = INF;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    initial begin
        bit rd;
        int w, ab;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 8; i++) pool[i] = 15'($urandom);
        pool[0] = 15'o12345;
        pool[1] = 15'o00200;

        reset      = 1;
        clear      = 0;
        data_break = 1;
        to_disk    = 0;
        dma_addr   = 15'o12345;
        dma_wdata  = 12'o7070;
        cycle_end  = 1;
        @(posedge clk);
        run = 1;
        repeat (3) step();

        do_xfer(0, 15'o12345, 12'o7070, 0, 0);
        do_xfer(1, 15'o00200, 12'o0000, 0, 0);
        idle(2);
        do_xfer(0, pool[2], 12'($urandom), 300, 0);
        do_xfer(1, 15'o12345, 12'o0000, 2, 0);
        do_xfer(0, pool[3], 12'($urandom), 4, 1);
        idle(1);
        do_xfer(1, 15'o00200, 12'o0000, 1, 2);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            rd = 1'($urandom);
            w  = $urandom_range(0, 6);
            ab = 0;
            if ($urandom_range(0, 7) == 0) ab = rd ? 2 : (w > 0 ? 1 : 0);
            do_xfer(rd, pool[$urandom_range(0, 7)], 12'($urandom), w, ab);
            idle($urandom_range(0, 3));
        end

        idle(8);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
